// File: rtl/sargantana_icache_mem_ctrl.sv
// rtl/sargantana_icache_mem_ctrl.sv - icache tag/data memory port arbiter with set-by-set flush walk
// Optional: SARGANTANA_ICACHE_FLUSH_ON_RESET_EN starts a full invalidate walk out of reset.
module sargantana_icache_mem_ctrl #(
  parameter int ICACHE_N_WAY = 4,
  parameter int TAG_DEPTH    = 64,
  parameter int ADDR_WIDHT   = $clog2(TAG_DEPTH),
  parameter int TAG_WIDHT    = 20,
  parameter int WAY_WIDHT    = 256,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    lu_valid_i,
  input  logic [ADDR_WIDHT-1:0]   lu_addr_i,
  output logic                    lu_ready_o,
  output logic                    lu_rvalid_o,
  input  logic                    rf_valid_i,
  input  logic [ADDR_WIDHT-1:0]   rf_addr_i,
  input  logic [ICACHE_N_WAY-1:0] rf_way_i,
  input  logic [TAG_WIDHT-1:0]    rf_tag_i,
  input  logic [WAY_WIDHT-1:0]    rf_line_i,
  output logic                    rf_ready_o,
  input  logic                    flush_i,
  output logic                    flush_busy_o,
  output logic                    flush_done_o,
  output logic [ICACHE_N_WAY-1:0] mem_tag_req_o,
  output logic [ICACHE_N_WAY-1:0] mem_data_req_o,
  output logic                    mem_tag_we_o,
  output logic                    mem_data_we_o,
  output logic                    mem_flush_en_o,
  output logic                    mem_valid_bit_o,
  output logic [ADDR_WIDHT-1:0]   mem_addr_o,
  output logic [TAG_WIDHT-1:0]    mem_tag_o,
  output logic [WAY_WIDHT-1:0]    mem_cline_o
);

  localparam int SCNT_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {IDLE, FLUSH} state_t;

`ifdef SARGANTANA_ICACHE_FLUSH_ON_RESET_EN
  localparam state_t RST_STATE = FLUSH;
`else
  localparam state_t RST_STATE = IDLE;
`endif

  state_t                r_state, w_state_nxt;
  logic                  r_flush_pend, w_flush_pend_nxt;
  logic [ADDR_WIDHT-1:0] r_fcnt, w_fcnt_nxt;
  logic [SCNT_W-1:0]     r_scnt, w_scnt_nxt;
  logic                  r_lu_rvalid, r_flush_done;
  logic                  w_lu_grant, w_rf_grant, w_walk_last;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= RST_STATE;
      r_flush_pend <= 1'b0;
      r_fcnt       <= '0;
      r_scnt       <= '0;
      r_lu_rvalid  <= 1'b0;
      r_flush_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_flush_pend <= w_flush_pend_nxt;
      r_fcnt       <= w_fcnt_nxt;
      r_scnt       <= w_scnt_nxt;
      r_lu_rvalid  <= w_lu_grant;
      r_flush_done <= w_walk_last;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_flush_pend_nxt = r_flush_pend;
    w_fcnt_nxt       = r_fcnt;
    w_scnt_nxt       = r_scnt;
    w_lu_grant       = 1'b0;
    w_rf_grant       = 1'b0;
    w_walk_last      = 1'b0;
    mem_tag_req_o    = '0;
    mem_data_req_o   = '0;
    mem_tag_we_o     = 1'b0;
    mem_data_we_o    = 1'b0;
    mem_flush_en_o   = 1'b0;
    mem_valid_bit_o  = 1'b0;
    mem_addr_o       = '0;
    mem_tag_o        = '0;
    mem_cline_o      = '0;
    if (!rst_i) begin
      case (r_state)
        FLUSH: begin
          mem_tag_req_o  = '1;
          mem_tag_we_o   = 1'b1;
          mem_flush_en_o = 1'b1;
          mem_addr_o     = r_fcnt;
          w_fcnt_nxt     = r_fcnt + 1'b1;
          if (r_fcnt == ADDR_WIDHT'(TAG_DEPTH - 1)) begin
            w_walk_last = 1'b1;
            w_state_nxt = IDLE;
          end
        end
        default: begin
          // A pending flush blocks grants; a fresh flush_i still lets this cycle's winner through.
          if (!r_flush_pend) begin
            if (lu_valid_i && (!rf_valid_i || r_scnt == SCNT_W'(STARVE_LIMIT))) begin
              w_lu_grant = 1'b1;
            end else if (rf_valid_i) begin
              w_rf_grant = 1'b1;
            end
          end
          if (w_lu_grant) begin
            mem_tag_req_o  = '1;
            mem_data_req_o = '1;
            mem_addr_o     = lu_addr_i;
            w_scnt_nxt     = '0;
          end
          if (w_rf_grant) begin
            mem_tag_req_o   = rf_way_i;
            mem_data_req_o  = rf_way_i;
            mem_tag_we_o    = 1'b1;
            mem_data_we_o   = 1'b1;
            mem_valid_bit_o = 1'b1;
            mem_addr_o      = rf_addr_i;
            mem_tag_o       = rf_tag_i;
            mem_cline_o     = rf_line_i;
            if (!lu_valid_i) begin
              w_scnt_nxt = '0;
            end else if (r_scnt != SCNT_W'(STARVE_LIMIT)) begin
              w_scnt_nxt = r_scnt + 1'b1;
            end
          end
          if (r_flush_pend || flush_i) begin
            w_state_nxt      = FLUSH;
            w_fcnt_nxt       = '0;
            w_flush_pend_nxt = 1'b0;
          end
        end
      endcase
    end
  end

  assign lu_ready_o   = w_lu_grant;
  assign rf_ready_o   = w_rf_grant;
  assign lu_rvalid_o  = r_lu_rvalid;
  assign flush_done_o = r_flush_done;
  assign flush_busy_o = r_flush_pend | (r_state == FLUSH);

endmodule

// File: tb/tb_sargantana_icache_mem_ctrl.sv
// tb/tb_sargantana_icache_mem_ctrl.sv - randomized and directed self-checking bench for sargantana_icache_mem_ctrl
module tb_sargantana_icache_mem_ctrl;

  localparam int N  = 4;
  localparam int D  = 64;
  localparam int AW = 6;
  localparam int TW = 20;
  localparam int WW = 256;
  localparam int SL = 4;
`ifdef SARGANTANA_ICACHE_FLUSH_ON_RESET_EN
  localparam bit FOR = 1'b1;
`else
  localparam bit FOR = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, lu_valid, rf_valid, flush;
  logic [AW-1:0] lu_addr, rf_addr;
  logic [N-1:0]  rf_way;
  logic [TW-1:0] rf_tag;
  logic [WW-1:0] rf_line;
  logic          lu_ready, lu_rvalid, rf_ready, busy, done;
  logic [N-1:0]  treq, dreq;
  logic          twe, dwe, fen, vb;
  logic [AW-1:0] maddr;
  logic [TW-1:0] mtag;
  logic [WW-1:0] mline;

  sargantana_icache_mem_ctrl dut (
    .clk_i(clk), .rst_i(rst),
    .lu_valid_i(lu_valid), .lu_addr_i(lu_addr), .lu_ready_o(lu_ready), .lu_rvalid_o(lu_rvalid),
    .rf_valid_i(rf_valid), .rf_addr_i(rf_addr), .rf_way_i(rf_way), .rf_tag_i(rf_tag),
    .rf_line_i(rf_line), .rf_ready_o(rf_ready),
    .flush_i(flush), .flush_busy_o(busy), .flush_done_o(done),
    .mem_tag_req_o(treq), .mem_data_req_o(dreq), .mem_tag_we_o(twe), .mem_data_we_o(dwe),
    .mem_flush_en_o(fen), .mem_valid_bit_o(vb), .mem_addr_o(maddr), .mem_tag_o(mtag),
    .mem_cline_o(mline)
  );

  // Reference state: is a walk running, which set it writes next, pending flag, refill streak.
  bit m_known = 1'b0;
  bit m_fl, m_pend, m_rv, m_done;
  int m_idx, m_sc;

  bit            s_lu_ready, s_rf_ready, s_rvalid, s_done, s_busy, s_twe, s_dwe, s_fen, s_vb;
  logic [N-1:0]  s_treq, s_dreq;
  logic [AW-1:0] s_addr;
  logic [TW-1:0] s_tag;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cycle();
    bit e_lr, e_rr, e_twe, e_dwe, e_fen, e_vb, lu_win, rf_win;
    logic [N-1:0]  e_treq, e_dreq;
    logic [AW-1:0] e_addr;
    logic [TW-1:0] e_tag;
    logic [WW-1:0] e_line;
    #2;
    e_lr = 0; e_rr = 0; e_twe = 0; e_dwe = 0; e_fen = 0; e_vb = 0; lu_win = 0; rf_win = 0;
    e_treq = '0; e_dreq = '0; e_addr = '0; e_tag = '0; e_line = '0;
    if (!rst && m_fl) begin
      e_treq = '1; e_twe = 1; e_fen = 1; e_addr = AW'(m_idx);
    end else if (!rst && !m_pend) begin
      lu_win = lu_valid && (!rf_valid || m_sc == SL);
      rf_win = rf_valid && !lu_win;
      if (lu_win) begin
        e_lr = 1; e_treq = '1; e_dreq = '1; e_addr = lu_addr;
      end else if (rf_win) begin
        e_rr = 1; e_treq = rf_way; e_dreq = rf_way; e_twe = 1; e_dwe = 1; e_vb = 1;
        e_addr = rf_addr; e_tag = rf_tag; e_line = rf_line;
      end
    end
    if (m_known) begin
      chk("lu_ready", lu_ready, e_lr);
      chk("rf_ready", rf_ready, e_rr);
      chk("tag_req", treq, e_treq);
      chk("data_req", dreq, e_dreq);
      chk("tag_we", twe, e_twe);
      chk("data_we", dwe, e_dwe);
      chk("flush_en", fen, e_fen);
      chk("valid_bit", vb, e_vb);
      chk("addr", maddr, e_addr);
      chk("tag", mtag, e_tag);
      chk("cline", mline, e_line);
      chk("lu_rvalid", lu_rvalid, m_rv);
      chk("flush_done", done, m_done);
      chk("flush_busy", busy, m_fl | m_pend);
    end
    s_lu_ready = lu_ready; s_rf_ready = rf_ready; s_rvalid = lu_rvalid; s_done = done;
    s_busy = busy; s_twe = twe; s_dwe = dwe; s_fen = fen; s_vb = vb;
    s_treq = treq; s_dreq = dreq; s_addr = maddr; s_tag = mtag;
    if (rst) begin
      m_known = 1; m_fl = FOR; m_idx = 0; m_pend = 0; m_sc = 0; m_rv = 0; m_done = 0;
    end else if (m_fl) begin
      m_rv = 0;
      m_done = (m_idx == D - 1);
      if (m_idx == D - 1) m_fl = 0;
      m_idx++;
    end else begin
      m_done = 0;
      m_rv = lu_win;
      if (lu_win) m_sc = 0;
      else if (rf_win) m_sc = lu_valid ? ((m_sc < SL) ? m_sc + 1 : SL) : 0;
      if (m_pend || flush) begin
        m_fl = 1; m_idx = 0; m_pend = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    lu_valid = 0; rf_valid = 0; flush = 0; rst = 0;
  endtask

  int done_at, fl_writes, done_cnt;
  bit [5:0] pat;

  initial begin
    rst = 1; lu_valid = 0; rf_valid = 0; flush = 0;
    lu_addr = '0; rf_addr = '0; rf_way = '0; rf_tag = '0; rf_line = '0;
    #1;
    cycle();
    cycle();
    quiet();
    cycle();
    chk("reset_busy", s_busy, FOR);
    chk("reset_rvalid", s_rvalid, 0);
    chk("reset_done", s_done, 0);
    if (FOR) begin
      for (int k = 0; k < D + 4; k++) cycle();
    end

    lu_valid = 1; lu_addr = 5;
    cycle();
    chk("lookup_ready", s_lu_ready, 1);
    chk("lookup_addr", s_addr, 5);
    chk("lookup_treq", s_treq, 4'b1111);
    chk("lookup_we", s_twe | s_dwe, 0);
    lu_valid = 0;
    cycle();
    chk("lookup_rvalid", s_rvalid, 1);

    rf_valid = 1; rf_way = 4'b0100; rf_addr = 9; rf_tag = 20'hABCDE; rf_line = {8{32'h1234_5678}};
    cycle();
    chk("refill_ready", s_rf_ready, 1);
    chk("refill_treq", s_treq, 4'b0100);
    chk("refill_dreq", s_dreq, 4'b0100);
    chk("refill_we", {s_twe, s_dwe, s_vb}, 3'b111);
    chk("refill_addr_tag", {s_addr, s_tag}, {6'd9, 20'hABCDE});
    chk("refill_no_lu", s_lu_ready, 0);

    rf_valid = 1; lu_valid = 1;
    for (int k = 0; k < 6; k++) begin
      cycle();
      pat[k] = s_rf_ready;
    end
    chk("starve_pattern", pat, 6'b101111);
    quiet();
    cycle();

    flush = 1;
    cycle();
    flush = 0;
    done_at = 0; fl_writes = 0;
    for (int k = 1; k <= 80; k++) begin
      flush = (k == 10);
      lu_valid = (k % 3 == 0); rf_valid = (k % 5 == 0);
      cycle();
      if (s_fen) fl_writes++;
      if (s_fen && (s_lu_ready || s_rf_ready)) chk("flush_blocks_ready", 1, 0);
      if (s_done && done_at == 0) done_at = k;
    end
    chk("flush_done_cycle", done_at, 65);
    chk("flush_write_count", fl_writes, 64);
    quiet();
    cycle();

    flush = 1;
    cycle();
    flush = 0;
    for (int k = 1; k < 20; k++) cycle();
    rst = 1;
    cycle();
    chk("rst_mid_walk_outputs", {s_fen, s_twe, s_treq}, 0);
    rst = 0;
    cycle();
    chk("post_rst_busy", s_busy, FOR);
    done_cnt = 0;
    for (int k = 0; k < 80; k++) begin
      cycle();
      if (s_done) done_cnt++;
    end
    chk("post_rst_done_pulses", done_cnt, FOR ? 1 : 0);

    for (int k = 0; k < 3000; k++) begin
      rst      = ($urandom_range(0, 499) == 0);
      flush    = ($urandom_range(0, 149) == 0);
      lu_valid = $urandom_range(0, 1);
      rf_valid = ($urandom_range(0, 3) != 0);
      lu_addr  = AW'($urandom);
      rf_addr  = AW'($urandom);
      rf_way   = N'(1) << $urandom_range(0, N - 1);
      rf_tag   = TW'($urandom);
      for (int w = 0; w < WW / 32; w++) rf_line[w*32 +: 32] = $urandom;
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
